// File: rtl/ntt_cmd_engine.sv
// Engine-side command responder: decodes LOAD/STORE/NTT/INTT commands and sequences
// the DMA beats, slot-bank accesses and NTT-core handshake needed to execute them.
module ntt_cmd_engine #(
    parameter int N      = 4096,
    parameter int WORD_W = 64,
    parameter int ADDR_W = 48,
    parameter int SLOT_W = 4,
    localparam int IDX_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    input  logic [7:0]        cmd_opcode,
    input  logic [SLOT_W-1:0] cmd_slot,
    input  logic [ADDR_W-1:0] cmd_dma_addr,
    output logic              engine_ready,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [SLOT_W-1:0] slot_sel,
    output logic [IDX_W-1:0]  slot_idx,
    output logic              slot_we,
    output logic [WORD_W-1:0] slot_wdata,
    output logic              slot_re,
    input  logic [WORD_W-1:0] slot_rdata,
    output logic              ntt_start,
    output logic              ntt_inverse,
    output logic [SLOT_W-1:0] ntt_slot,
    input  logic              ntt_done,
    output logic              err_opcode,
    output logic              err_align,
    output logic              err_overrun,
    output logic [15:0]       cmds_done
);

    localparam logic [7:0]        OP_LOAD  = 8'h01;
    localparam logic [7:0]        OP_STORE = 8'h02;
    localparam logic [7:0]        OP_INTT  = 8'h04;
    localparam logic [ADDR_W-1:0] BEAT     = ADDR_W'(4'd8);

    typedef enum logic [3:0] {
        IDLE, LD_REQ, LD_WR, ST_RD, ST_WAIT, ST_REQ, NTT_START, NTT_WAIT, DONE
    } state_t;

    state_t              state_r, state_s;
    logic                ready_r, mem_req_r, mem_we_r, slot_we_r, slot_re_r, ntt_start_r;
    logic                inverse_r, err_opcode_r, err_align_r, err_overrun_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [WORD_W-1:0]   data_r;
    logic [SLOT_W-1:0]   slot_r;
    logic [IDX_W-1:0]    idx_r;
    logic [15:0]         cmds_r;
    logic                accept_s, illegal_s, ls_s, misaligned_s, last_s;

    assign accept_s     = cmd_valid && (state_r == IDLE);
    assign illegal_s    = (cmd_opcode < 8'h01) || (cmd_opcode > 8'h04);
    assign ls_s         = (cmd_opcode == OP_LOAD) || (cmd_opcode == OP_STORE);
    assign misaligned_s = (cmd_dma_addr[2:0] != 3'd0);
    assign last_s       = (idx_r == IDX_W'(N - 1));

    // Next-state decode; error-terminated commands still pass through DONE.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    if (illegal_s) state_s = DONE;
                    else if (ls_s && misaligned_s) state_s = DONE;
                    else if (cmd_opcode == OP_LOAD) state_s = LD_REQ;
                    else if (cmd_opcode == OP_STORE) state_s = ST_RD;
                    else state_s = NTT_START;
                end else begin
                    state_s = IDLE;
                end
            end
            LD_REQ:    state_s = mem_ack ? LD_WR : LD_REQ;
            LD_WR:     state_s = last_s ? DONE : LD_REQ;
            ST_RD:     state_s = ST_WAIT;
            ST_WAIT:   state_s = ST_REQ;
            ST_REQ: begin
                if (mem_ack) state_s = last_s ? DONE : ST_RD;
                else state_s = ST_REQ;
            end
            NTT_START: state_s = NTT_WAIT;
            NTT_WAIT:  state_s = ntt_done ? DONE : NTT_WAIT;
            DONE:      state_s = IDLE;
            default:   state_s = IDLE;
        endcase
    end

    // State, registered strobes (decoded from the next state) and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= IDLE;
            ready_r       <= 1'b1;
            mem_req_r     <= 1'b0;
            mem_we_r      <= 1'b0;
            slot_we_r     <= 1'b0;
            slot_re_r     <= 1'b0;
            ntt_start_r   <= 1'b0;
            inverse_r     <= 1'b0;
            err_opcode_r  <= 1'b0;
            err_align_r   <= 1'b0;
            err_overrun_r <= 1'b0;
            addr_r        <= '0;
            data_r        <= '0;
            slot_r        <= '0;
            idx_r         <= '0;
            cmds_r        <= 16'd0;
        end else begin
            state_r       <= state_s;
            ready_r       <= (state_s == IDLE);
            mem_req_r     <= (state_s == LD_REQ) || (state_s == ST_REQ);
            mem_we_r      <= (state_s == ST_REQ);
            slot_we_r     <= (state_s == LD_WR);
            slot_re_r     <= (state_s == ST_RD);
            ntt_start_r   <= (state_s == NTT_START);
            err_opcode_r  <= err_opcode_r | (accept_s & illegal_s);
            err_align_r   <= err_align_r | (accept_s & ls_s & misaligned_s);
            err_overrun_r <= err_overrun_r | (cmd_valid & ~ready_r);
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        slot_r    <= cmd_slot;
                        addr_r    <= cmd_dma_addr;
                        inverse_r <= (cmd_opcode == OP_INTT);
                        idx_r     <= '0;
                    end
                end
                LD_REQ: begin
                    if (mem_ack) data_r <= mem_rdata;
                end
                LD_WR: begin
                    idx_r  <= idx_r + IDX_W'(1'b1);
                    addr_r <= addr_r + BEAT;
                end
                ST_WAIT: data_r <= slot_rdata;
                ST_REQ: begin
                    if (mem_ack) begin
                        idx_r  <= idx_r + IDX_W'(1'b1);
                        addr_r <= addr_r + BEAT;
                    end
                end
                DONE:    cmds_r <= cmds_r + 16'd1;
                default: ;
            endcase
        end
    end

    // One data register serves both directions: load beats land in the slot, store beats go to host.
    assign engine_ready = ready_r;
    assign mem_req      = mem_req_r;
    assign mem_we       = mem_we_r;
    assign mem_addr     = addr_r;
    assign mem_wdata    = data_r;
    assign slot_sel     = slot_r;
    assign slot_idx     = idx_r;
    assign slot_we      = slot_we_r;
    assign slot_wdata   = data_r;
    assign slot_re      = slot_re_r;
    assign ntt_start    = ntt_start_r;
    assign ntt_inverse  = inverse_r;
    assign ntt_slot     = slot_r;
    assign err_opcode   = err_opcode_r;
    assign err_align    = err_align_r;
    assign err_overrun  = err_overrun_r;
    assign cmds_done    = cmds_r;

endmodule

// File: tb/tb_ntt_cmd_engine.sv
// Scoreboard bench for ntt_cmd_engine (N=4): a command-level model queues expected DMA beats,
// slot writes, NTT pulses and completion counts; a negedge monitor pops and compares them.
module tb_ntt_cmd_engine;
    localparam int N      = 4;
    localparam int WORD_W = 64;
    localparam int ADDR_W = 48;
    localparam int SLOT_W = 4;
    localparam int IDX_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n, cmd_valid, mem_ack, ntt_done;
    logic [7:0]        cmd_opcode;
    logic [SLOT_W-1:0] cmd_slot;
    logic [ADDR_W-1:0] cmd_dma_addr;
    logic [WORD_W-1:0] mem_rdata, slot_rdata;
    logic              engine_ready, mem_req, mem_we, slot_we, slot_re, ntt_start, ntt_inverse;
    logic              err_opcode, err_align, err_overrun;
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_wdata, slot_wdata;
    logic [SLOT_W-1:0] slot_sel, ntt_slot;
    logic [IDX_W-1:0]  slot_idx;
    logic [15:0]       cmds_done;

    ntt_cmd_engine #(.N(N), .WORD_W(WORD_W), .ADDR_W(ADDR_W), .SLOT_W(SLOT_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
        .cmd_slot(cmd_slot), .cmd_dma_addr(cmd_dma_addr), .engine_ready(engine_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .slot_sel(slot_sel), .slot_idx(slot_idx),
        .slot_we(slot_we), .slot_wdata(slot_wdata), .slot_re(slot_re), .slot_rdata(slot_rdata),
        .ntt_start(ntt_start), .ntt_inverse(ntt_inverse), .ntt_slot(ntt_slot),
        .ntt_done(ntt_done), .err_opcode(err_opcode), .err_align(err_align),
        .err_overrun(err_overrun), .cmds_done(cmds_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [47:0] addr; logic [63:0] data; } mem_exp_t;
    typedef struct { logic [3:0] sel; logic [1:0] idx; logic [63:0] data; } slot_exp_t;
    typedef struct { logic inv; logic [3:0] slot; } ntt_exp_t;

    mem_exp_t    exp_mem[$];
    slot_exp_t   exp_slot[$];
    ntt_exp_t    exp_ntt[$];
    logic [15:0] exp_done[$];

    logic [63:0] slot_ram [16][4];
    logic [63:0] ref_slot [16][4];
    logic        m_err_opcode, m_err_align, m_err_overrun;
    logic [15:0] m_cmds;
    int          n_vec = 0;
    int          n_err = 0;
    int          ntt_delay = 5;
    int          ntt_cnt = 0;
    bit          spur_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Host memory contents: test-plan bytes A0..A3 at 0x1000, an address hash elsewhere.
    function automatic logic [63:0] host_data(input logic [47:0] a);
        logic [1:0] w;
        w = a[4:3];
        if (a >= 48'h1000 && a < 48'h1020) host_data = 64'hA0 + 64'(w);
        else host_data = {16'h5A5A, a} ^ 64'hDEAD_BEEF_0000_0000;
    endfunction

    // Command-level reference: what each command must produce, and its fixed latency if any.
    task automatic model_cmd(input logic [7:0] op, input logic [3:0] slot, input logic [47:0] addr,
                             output int lat);
        logic [47:0] a;
        lat = -1;
        m_cmds = m_cmds + 16'd1;
        exp_done.push_back(m_cmds);
        if (op == 8'h01 || op == 8'h02) begin
            if (addr[2:0] != 3'd0) begin
                m_err_align = 1'b1;
                lat = 1;
            end else begin
                for (int i = 0; i < N; i++) begin
                    a = addr + 48'(8 * i);
                    if (op == 8'h01) begin
                        exp_mem.push_back('{we: 1'b0, addr: a, data: 64'd0});
                        exp_slot.push_back('{sel: slot, idx: 2'(i), data: host_data(a)});
                        ref_slot[slot][i] = host_data(a);
                    end else begin
                        exp_mem.push_back('{we: 1'b1, addr: a, data: ref_slot[slot][i]});
                    end
                end
            end
        end else if (op == 8'h03 || op == 8'h04) begin
            exp_ntt.push_back('{inv: (op == 8'h04), slot: slot});
            lat = ntt_delay + 2;
        end else begin
            m_err_opcode = 1'b1;
            lat = 1;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", 64'(engine_ready), 64'd1);
        chk("rst_ctl", 64'({mem_req, mem_we, slot_we, slot_re, ntt_start, ntt_inverse,
                            err_opcode, err_align, err_overrun}), 64'd0);
        chk("rst_mem_addr", 64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_slot", 64'({slot_sel, slot_idx, ntt_slot}), 64'd0);
        chk("rst_slot_wdata", slot_wdata, 64'd0);
        chk("rst_cmds_done", 64'(cmds_done), 64'd0);
        exp_mem.delete(); exp_slot.delete(); exp_ntt.delete(); exp_done.delete();
        m_err_opcode = 1'b0; m_err_align = 1'b0; m_err_overrun = 1'b0; m_cmds = 16'd0;
        repeat (cycles - 1) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Issue one command (engine_ready must be 1), optionally strobe an overrun, wait for completion.
    task automatic run_cmd(input logic [7:0] op, input logic [3:0] slot, input logic [47:0] addr,
                           input int ov);
        int k, lat;
        model_cmd(op, slot, addr, lat);
        cmd_opcode = op; cmd_slot = slot; cmd_dma_addr = addr; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("ready_drop", 64'(engine_ready), 64'd0);
        for (k = 0; k < 3000 && engine_ready !== 1'b1; k++) begin
            if (k == ov) begin
                cmd_valid = 1'b1; cmd_opcode = 8'h03; cmd_slot = ~slot; cmd_dma_addr = ~addr;
                m_err_overrun = 1'b1;
            end
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        end
        chk("cmd_completes", 64'(engine_ready), 64'd1);
        if (lat >= 0) chk("cmd_latency", 64'(k), 64'(lat));
        chk("err_opcode", 64'(err_opcode), 64'(m_err_opcode));
        chk("err_align", 64'(err_align), 64'(m_err_align));
        chk("err_overrun", 64'(err_overrun), 64'(m_err_overrun));
    endtask

    // Monitor: every DUT-presented event is matched against the head of its expectation queue.
    initial begin : monitor
        logic      prev_ready;
        mem_exp_t  me;
        slot_exp_t se;
        ntt_exp_t  ne;
        prev_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_ready = 1'b1;
            end else begin
                if (mem_req === 1'b1) begin
                    if (exp_mem.size() == 0) chk("mem_req_unexpected", 64'(mem_req), 64'd0);
                    else begin
                        me = exp_mem[0];
                        chk("mem_addr", 64'(mem_addr), 64'(me.addr));
                        chk("mem_we", 64'(mem_we), 64'(me.we));
                        if (me.we) chk("mem_wdata", mem_wdata, me.data);
                        if (mem_ack === 1'b1) void'(exp_mem.pop_front());
                    end
                end
                if (slot_we === 1'b1) begin
                    if (exp_slot.size() == 0) chk("slot_we_unexpected", 64'(slot_we), 64'd0);
                    else begin
                        se = exp_slot.pop_front();
                        chk("slot_sel", 64'(slot_sel), 64'(se.sel));
                        chk("slot_idx", 64'(slot_idx), 64'(se.idx));
                        chk("slot_wdata", slot_wdata, se.data);
                    end
                end
                if (ntt_start === 1'b1) begin
                    if (exp_ntt.size() == 0) chk("ntt_start_unexpected", 64'(ntt_start), 64'd0);
                    else begin
                        ne = exp_ntt.pop_front();
                        chk("ntt_inverse", 64'(ntt_inverse), 64'(ne.inv));
                        chk("ntt_slot", 64'(ntt_slot), 64'(ne.slot));
                    end
                end
                if (engine_ready === 1'b1 && prev_ready === 1'b0) begin
                    if (exp_done.size() == 0) chk("ready_unexpected", 64'(engine_ready), 64'd0);
                    else chk("cmds_done", 64'(cmds_done), 64'(exp_done.pop_front()));
                end
                prev_ready = engine_ready;
            end
        end
    end

    // Host DMA responder: 0-2 cycle ack delay, one-cycle ack, occasional stray acks when idle.
    initial begin : mem_resp
        int dly;
        dly = $urandom_range(0, 2);
        forever begin
            @(posedge clk); #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end else if (mem_req === 1'b1) begin
                if (dly == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = host_data(mem_addr);
                    dly = $urandom_range(0, 2);
                end else begin
                    dly--;
                end
            end else if (spur_en && $urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;
                mem_rdata = {$urandom, $urandom};
            end
        end
    end

    // Slot bank: read data valid only in the cycle after slot_re, garbage otherwise.
    initial begin : slot_bank
        logic       rd_pend;
        logic [3:0] rd_sel;
        logic [1:0] rd_idx;
        rd_pend = 1'b0; rd_sel = 4'd0; rd_idx = 2'd0;
        forever begin
            @(posedge clk); #1;
            if (rd_pend) slot_rdata = slot_ram[rd_sel][rd_idx];
            else slot_rdata = {$urandom, $urandom};
            rd_pend = (slot_re === 1'b1);
            rd_sel = slot_sel;
            rd_idx = slot_idx;
            if (slot_we === 1'b1) slot_ram[slot_sel][slot_idx] = slot_wdata;
        end
    end

    // NTT core stub: done pulse ntt_delay cycles after start, stray pulses only while nothing runs.
    initial begin : ntt_stub
        forever begin
            @(posedge clk); #1;
            ntt_done = 1'b0;
            if (ntt_start === 1'b1) ntt_cnt = ntt_delay;
            else if (ntt_cnt > 0) begin
                ntt_cnt--;
                if (ntt_cnt == 0) ntt_done = 1'b1;
            end else if (spur_en && $urandom_range(0, 9) == 0) ntt_done = 1'b1;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int lat;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_opcode = 8'h00; cmd_slot = 4'd0;
        cmd_dma_addr = 48'd0; mem_ack = 1'b0; mem_rdata = 64'd0; slot_rdata = 64'd0;
        ntt_done = 1'b0;
        for (int s = 0; s < 16; s++)
            for (int i = 0; i < N; i++) begin
                slot_ram[s][i] = {$urandom, $urandom};
                ref_slot[s][i] = slot_ram[s][i];
            end
        for (int i = 0; i < N; i++) begin
            slot_ram[2][i] = 64'hB0 + 64'(i);
            ref_slot[2][i] = 64'hB0 + 64'(i);
        end

        do_reset(2);
        run_cmd(8'h01, 4'd3, 48'h1000, -1);
        run_cmd(8'h02, 4'd2, 48'hFFFF_FFFF_FFF8, -1);
        ntt_delay = 20;
        run_cmd(8'h04, 4'd5, 48'h0, -1);
        ntt_delay = 3;
        run_cmd(8'h03, 4'd9, 48'h0, -1);
        run_cmd(8'h7F, 4'd1, 48'h2000, -1);
        run_cmd(8'h01, 4'd4, 48'h1004, -1);
        run_cmd(8'h01, 4'd6, 48'h1000, 3);
        run_cmd(8'h02, 4'd3, 48'h4000, -1);

        spur_en = 1'b1;
        for (int c = 0; c < 40; c++) begin
            int          r, ov;
            logic [7:0]  op;
            logic [47:0] a;
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: op = 8'h01;
                3, 4, 5: op = 8'h02;
                6:       op = 8'h03;
                7:       op = 8'h04;
                8:       op = 8'h00;
                default: op = 8'($urandom_range(5, 255));
            endcase
            a = {16'($urandom), 32'($urandom)};
            a[2:0] = 3'd0;
            if ($urandom_range(0, 5) == 0) a[2:0] = 3'($urandom_range(1, 7));
            ov = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
            ntt_delay = $urandom_range(1, 25);
            run_cmd(op, 4'($urandom), a, ov);
        end

        // Abort a LOAD mid-flight, then reload and read back the same slot.
        spur_en = 1'b0;
        model_cmd(8'h01, 4'd7, 48'h1000, lat);
        cmd_opcode = 8'h01; cmd_slot = 4'd7; cmd_dma_addr = 48'h1000; cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        do_reset(2);
        run_cmd(8'h01, 4'd7, 48'h1000, -1);
        run_cmd(8'h02, 4'd7, 48'h8000, -1);
        run_cmd(8'h02, 4'd3, 48'h0FF8, -1);

        repeat (3) @(posedge clk);
        #1;
        chk("leftover_mem", 64'(exp_mem.size()), 64'd0);
        chk("leftover_slot", 64'(exp_slot.size()), 64'd0);
        chk("leftover_ntt", 64'(exp_ntt.size()), 64'd0);
        chk("leftover_done", 64'(exp_done.size()), 64'd0);
        chk("final_cmds_done", 64'(cmds_done), 64'(m_cmds));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ntt_cmd_engine.md
Name: ntt_cmd_engine

Overview:
Engine-side responder for the command stream issued by the command processor. It accepts single-cycle cmd_valid pulses while engine_ready is high and decodes the opcode. It then runs the command: a DMA load from host memory into a polynomial slot, a DMA store from a slot to host memory, or a forward or inverse NTT on a slot. It drops engine_ready for the whole execution and raises it again on completion.

Parameters:
N, 4096, coefficients per slot (power of two, >=2)
WORD_W, 64, coefficient width in bits, one DMA beat per coefficient
ADDR_W, 48, DMA byte-address width
SLOT_W, 4, slot index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
cmd_valid  in  1  one-cycle command strobe
cmd_opcode  in  8  01 LOAD, 02 STORE, 03 NTT, 04 INTT
cmd_slot  in  SLOT_W  target slot
cmd_dma_addr  in  ADDR_W  host byte base address
engine_ready  out  1  high = idle, accepting a command
mem_req  out  1  DMA request, held until mem_ack
mem_we  out  1  1 = write beat (STORE)
mem_addr  out  ADDR_W  beat byte address
mem_wdata  out  WORD_W  store data
mem_ack  in  1  beat complete; rdata valid same cycle for reads
mem_rdata  in  WORD_W  load data
slot_sel  out  SLOT_W  slot bank select
slot_idx  out  log2(N)  coefficient index
slot_we  out  1  slot write strobe
slot_wdata  out  WORD_W  slot write data
slot_re  out  1  slot read strobe; slot_rdata valid the next cycle
slot_rdata  in  WORD_W  slot read data
ntt_start  out  1  one-cycle NTT start pulse
ntt_inverse  out  1  1 = INTT, valid with ntt_start
ntt_slot  out  SLOT_W  slot for the NTT, valid with ntt_start
ntt_done  in  1  NTT core completion pulse
err_opcode  out  1  sticky, illegal opcode received
err_align  out  1  sticky, cmd_dma_addr[2:0] != 0 on LOAD/STORE
err_overrun  out  1  sticky, cmd_valid while engine_ready low
cmds_done  out  16  completed-command counter, wraps

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; engine_ready=1; every other output 0. Reset mid-command aborts the command at once: mem_req drops on that edge, and no slot write, NTT pulse or counter update happens. Sticky errors clear only on reset.
- engine_ready is registered. If cmd_valid is high in a cycle with engine_ready=1, the command is captured at that edge and engine_ready is 0 from the next cycle on.
- States:
  - IDLE -> LD_REQ, ST_RD, NTT_START or DONE, chosen by opcode and error checks.
  - Illegal opcode, including 00: set err_opcode, go to DONE.
  - LOAD/STORE with misaligned address: set err_align, go to DONE.
- LOAD, beat i = 0..N-1:
  - LD_REQ: mem_req=1, mem_we=0, mem_addr = base + 8*i (mod 2^ADDR_W).
  - Hold request until mem_ack. In the ack cycle, capture rdata.
  - Next cycle: slot_we=1, slot_idx=i, slot_wdata=data. Then move to the next beat, or to DONE after i=N-1.
- STORE, beat i:
  - ST_RD: slot_re=1, slot_idx=i.
  - ST_WAIT: capture slot_rdata.
  - ST_REQ: mem_req=1, mem_we=1, mem_addr = base + 8*i, mem_wdata held stable until mem_ack. Then move to the next beat, or to DONE.
- mem_addr, mem_we and mem_wdata must not change while mem_req=1 and mem_ack=0. mem_req drops in the cycle after the ack.
- NTT/INTT:
  - NTT_START: ntt_start=1 for exactly one cycle, with ntt_inverse and ntt_slot.
  - NTT_WAIT: wait for ntt_done. An ntt_done seen in any other state is ignored.
- DONE (1 cycle): cmds_done += 1, including error-terminated commands. engine_ready=1 from the next cycle.
- mem_ack while mem_req=0 is ignored.
- cmd_valid with engine_ready=0 is ignored and sets err_overrun. The running command is not disturbed.
- slot_sel holds the captured slot for the whole command.

Test Plan:
- Reset with rst_n=0 for 2 cycles -> engine_ready=1, every other output 0, cmds_done=0.
- N=4, LOAD slot 3 at base 0x1000, mem_ack returns rdata 0xA0..0xA3 after 0-2 cycles of delay -> mem_addr sequence 0x1000, 0x1008, 0x1010, 0x1018 held stable while waiting for ack; slot writes idx 0..3 with 0xA0..0xA3, slot_sel=3; cmds_done=1; engine_ready=1 again.
- N=4, STORE slot 2 at base 0xFFFF_FFFF_FFF8 with slot contents 0xB0..0xB3 -> slot_re then mem writes; second beat address wraps to 0x0; mem_wdata 0xB0..0xB3.
- Opcode 0x04 slot 5 -> one ntt_start pulse with ntt_inverse=1 and ntt_slot=5; engine_ready stays 0 until ntt_done arrives 20 cycles later, then returns to 1 after DONE.
- Opcode 0x7F, then LOAD at 0x1004 -> err_opcode=1 and err_align=1; no mem_req; cmds_done=2.
- cmd_valid during a LOAD, and rst_n low mid-LOAD -> err_overrun=1 with the load unaffected; reset drops mem_req and returns to IDLE with cmds_done=0.
